// File: rtl/coin_lock_ctrl.sv
// -----------------------------------------------------------------------------
// coin_lock_ctrl
//   Coin-operated lock controller. Coins are counted into a credit register.
//   When the credit reaches PRICE the controller becomes READY and releases the
//   lock. A start request consumes the credit and re-locks. If READY sees no
//   start for TIMEOUT cycles, the credit is refunded. Coins offered while READY
//   are refunded as overpayment.
//
// Parameters
//   MEALY_FSM : 0 = lock is a pure function of the registered state,
//               1 = lock also reacts combinationally to coin/start.
//   PRICE     : coins required per unlock (1 .. 2**CNT_W-1).
//   CNT_W     : width of the credit counter.
//   TIMEOUT   : READY cycles without start before refund; 0 = wait forever.
//
// Ports
//   clk       in   single clock, rising edge
//   rst       in   asynchronous active-high reset
//   coin      in   one coin per cycle it is high
//   start     in   user start request
//   lock      out  1 = mechanism locked (forced 1 while rst is high)
//   unlock    out  always ~lock
//   credit    out  registered count of accepted coins
//   refund    out  registered one-cycle pulse per refund event
//   dbg_state out  registered FSM state: 0 = IDLE, 1 = COLLECT, 2 = READY
//
// Input semantics: coin and start are level-sampled strobes with no
// handshake. Every cycle in which coin is high is one coin; start is acted
// on only in a cycle where the registered state is READY and is otherwise
// dropped. Neither input is ever back-pressured.
// -----------------------------------------------------------------------------
module coin_lock_ctrl #(
  parameter logic MEALY_FSM = 1'b0,
  parameter int   PRICE     = 3,
  parameter int   CNT_W     = 4,
  parameter int   TIMEOUT   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             coin,
  input  logic             start,
  output logic             lock,
  output logic             unlock,
  output logic [CNT_W-1:0] credit,
  output logic             refund,
  output logic [1:0]       dbg_state
);

  // The wait counter only ever needs to hold 0 .. TIMEOUT-1.
  localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = (TIMEOUT > 0) ? TMO_W'(TIMEOUT - 1) : '0;
  localparam logic [CNT_W-1:0] PRICE_C  = CNT_W'(PRICE);
  localparam logic [CNT_W-1:0] ONE_C    = CNT_W'(1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_READY   = 2'd2
  } state_t;

  // A coin arriving on timeout expiry starts a new transaction with credit 1,
  // which is already a full payment when PRICE is 1.
  localparam state_t EXPIRY_COIN_ST = (PRICE == 1) ? S_READY : S_COLLECT;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   credit_q, credit_d;
  logic [TMO_W-1:0]   tmo_q, tmo_d;
  logic               refund_q, refund_d;
  logic [CNT_W-1:0]   credit_inc;
  logic               tmo_expire;
  logic               lock_c;

  // credit_q < PRICE whenever it is incremented, so this cannot wrap.
  assign credit_inc = credit_q + ONE_C;
  assign tmo_expire = (TIMEOUT != 0) && (tmo_q == TMO_LAST);

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      credit_q <= '0;
      tmo_q    <= '0;
      refund_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      credit_q <= credit_d;
      tmo_q    <= tmo_d;
      refund_q <= refund_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d  = state_q;
    credit_d = credit_q;
    tmo_d    = tmo_q;
    refund_d = 1'b0;
    case (state_q)
      S_IDLE, S_COLLECT: begin
        if (coin) begin
          credit_d = credit_inc;
          if (credit_inc == PRICE_C) begin
            state_d = S_READY;
            tmo_d   = '0;
          end else begin
            state_d = S_COLLECT;
          end
        end
      end
      S_READY: begin
        if (start) begin
          // Start wins over a simultaneous coin; that coin is refunded.
          state_d  = S_IDLE;
          credit_d = '0;
          tmo_d    = '0;
          refund_d = coin;
        end else if (tmo_expire) begin
          refund_d = 1'b1;
          tmo_d    = '0;
          if (coin) begin
            credit_d = ONE_C;
            state_d  = EXPIRY_COIN_ST;
          end else begin
            credit_d = '0;
            state_d  = S_IDLE;
          end
        end else begin
          tmo_d    = (TIMEOUT == 0) ? '0 : tmo_q + TMO_W'(1);
          refund_d = coin;
        end
      end
      default: begin
        state_d  = S_IDLE;
        credit_d = '0;
        tmo_d    = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    lock_c = (state_q != S_READY);
    if (MEALY_FSM) begin
      if ((state_q != S_READY) && coin && (credit_inc == PRICE_C)) begin
        lock_c = 1'b0;
      end else if ((state_q == S_READY) && start) begin
        lock_c = 1'b1;
      end
    end
    // Reset must lock immediately, even against a live coin in Mealy mode.
    lock = rst | lock_c;
  end

  assign unlock    = ~lock;
  assign credit    = credit_q;
  assign refund    = refund_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_coin_lock_ctrl.sv
// -----------------------------------------------------------------------------
// tb_coin_lock_ctrl
//   Five coin_lock_ctrl instances with different parameter sets share one
//   stimulus stream. A credit-level reference model per instance predicts
//   credit, lock, unlock, refund and state every cycle.
//     inst 0: Moore, PRICE 3, CNT_W 4, TIMEOUT 8
//     inst 1: Mealy, PRICE 3, CNT_W 4, TIMEOUT 8
//     inst 2: Moore, PRICE 1, CNT_W 4, TIMEOUT 0
//     inst 3: Mealy, PRICE 3, CNT_W 2, TIMEOUT 1  (credit at counter maximum)
//     inst 4: Moore, PRICE 1, CNT_W 1, TIMEOUT 3
// -----------------------------------------------------------------------------
module tb_coin_lock_ctrl;

  localparam int N = 5;
  localparam int P[N] = '{3, 3, 1, 3, 1};
  localparam int T[N] = '{8, 8, 0, 1, 3};
  localparam int M[N] = '{0, 1, 0, 1, 0};

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic coin = 1'b0;
  logic start = 1'b0;

  always #5 clk = ~clk;

  // ---------------------------------------------------------------- DUTs
  logic       lock_w[N];
  logic       unlock_w[N];
  logic       refund_w[N];
  logic [1:0] st_w[N];
  logic [3:0] cr0, cr1, cr2;
  logic [1:0] cr3;
  logic [0:0] cr4;

  coin_lock_ctrl #(.MEALY_FSM(1'b0), .PRICE(3), .CNT_W(4), .TIMEOUT(8)) u0 (
    .clk(clk), .rst(rst), .coin(coin), .start(start), .lock(lock_w[0]),
    .unlock(unlock_w[0]), .credit(cr0), .refund(refund_w[0]), .dbg_state(st_w[0]));
  coin_lock_ctrl #(.MEALY_FSM(1'b1), .PRICE(3), .CNT_W(4), .TIMEOUT(8)) u1 (
    .clk(clk), .rst(rst), .coin(coin), .start(start), .lock(lock_w[1]),
    .unlock(unlock_w[1]), .credit(cr1), .refund(refund_w[1]), .dbg_state(st_w[1]));
  coin_lock_ctrl #(.MEALY_FSM(1'b0), .PRICE(1), .CNT_W(4), .TIMEOUT(0)) u2 (
    .clk(clk), .rst(rst), .coin(coin), .start(start), .lock(lock_w[2]),
    .unlock(unlock_w[2]), .credit(cr2), .refund(refund_w[2]), .dbg_state(st_w[2]));
  coin_lock_ctrl #(.MEALY_FSM(1'b1), .PRICE(3), .CNT_W(2), .TIMEOUT(1)) u3 (
    .clk(clk), .rst(rst), .coin(coin), .start(start), .lock(lock_w[3]),
    .unlock(unlock_w[3]), .credit(cr3), .refund(refund_w[3]), .dbg_state(st_w[3]));
  coin_lock_ctrl #(.MEALY_FSM(1'b0), .PRICE(1), .CNT_W(1), .TIMEOUT(3)) u4 (
    .clk(clk), .rst(rst), .coin(coin), .start(start), .lock(lock_w[4]),
    .unlock(unlock_w[4]), .credit(cr4), .refund(refund_w[4]), .dbg_state(st_w[4]));

  function automatic int credit_of(input int k);
    case (k)
      0: return int'(cr0);
      1: return int'(cr1);
      2: return int'(cr2);
      3: return int'(cr3);
      default: return int'(cr4);
    endcase
  endfunction

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: a transaction is just an accepted-coin count and, once
  // fully paid, a count of cycles spent waiting for start.
  int m_credit[N];
  int m_wait[N];
  logic [N-1:0] exp_q[$];  // expected refund vector, one entry per clock edge

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_credit[k] = 0;
      m_wait[k]   = 0;
    end
    exp_q.delete();
  endtask

  task automatic model_step(input logic c, input logic s);
    logic [N-1:0] rf;
    rf = '0;
    for (int k = 0; k < N; k++) begin
      if (m_credit[k] < P[k]) begin
        if (c) begin
          m_credit[k]++;
          m_wait[k] = 0;
        end
      end else if (s) begin
        m_credit[k] = 0;
        rf[k] = c;
      end else if (T[k] != 0 && m_wait[k] == T[k] - 1) begin
        rf[k] = 1'b1;
        m_credit[k] = c ? 1 : 0;
        m_wait[k] = 0;
      end else begin
        m_wait[k]++;
        rf[k] = c;
      end
    end
    exp_q.push_back(rf);
  endtask

  task automatic check_all();
    logic [N-1:0] exp_rf;
    logic [N-1:0] got_rf;
    logic el;
    bit   paid;
    int   es;
    exp_rf = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
    for (int k = 0; k < N; k++) begin
      got_rf[k] = refund_w[k];
      paid = (m_credit[k] == P[k]);
      el = !paid;
      if (M[k] != 0) begin
        if (!paid && coin && (m_credit[k] + 1 == P[k])) el = 1'b0;
        else if (paid && start) el = 1'b1;
      end
      if (rst) el = 1'b1;
      es = paid ? 2 : (m_credit[k] == 0 ? 0 : 1);
      check($sformatf("i%0d.credit", k), credit_of(k), m_credit[k]);
      check($sformatf("i%0d.lock", k), lock_w[k], el);
      check($sformatf("i%0d.unlock", k), unlock_w[k], !el);
      check($sformatf("i%0d.state", k), st_w[k], es);
    end
    check("refund_vec", got_rf, exp_rf);
  endtask

  // ---------------------------------------------------------------- drivers
  task automatic step_pre(input logic c, input logic s);
    coin  = c;
    start = s;
    #1;
    check_all();
  endtask

  task automatic step_post();
    @(posedge clk);
    model_step(coin, start);
    #1;
  endtask

  task automatic step(input logic c, input logic s);
    step_pre(c, s);
    step_post();
  endtask

  // Called between edges; reset must act before any clock edge.
  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
    for (int k = 0; k < N; k++) begin
      check($sformatf("rst.i%0d.credit", k), credit_of(k), 0);
      check($sformatf("rst.i%0d.lock", k), lock_w[k], 1);
      check($sformatf("rst.i%0d.unlock", k), unlock_w[k], 0);
      check($sformatf("rst.i%0d.refund", k), refund_w[k], 0);
    end
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    model_reset();
    #2;
    do_reset();

    // Moore/Mealy unlock sequence at PRICE 3
    step(1'b1, 1'b0);
    check("seq.credit1", credit_of(0), 1);
    step(1'b1, 1'b0);
    check("seq.credit2", credit_of(0), 2);
    step_pre(1'b1, 1'b0);
    check("seq.mealy_lock_on_coin", lock_w[1], 0);
    check("seq.moore_lock_on_coin", lock_w[0], 1);
    step_post();
    check("seq.credit3", credit_of(0), 3);
    check("seq.moore_unlocked", lock_w[0], 0);
    step_pre(1'b0, 1'b1);
    check("seq.mealy_lock_on_start", lock_w[1], 1);
    check("seq.moore_lock_on_start", lock_w[0], 0);
    step_post();
    check("seq.credit_cleared", credit_of(0), 0);
    check("seq.moore_relocked", lock_w[0], 1);

    // Overpayment, then coin+start together
    repeat (3) step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("ovp.credit_kept", credit_of(0), 3);
    check("ovp.refund", refund_w[0], 1);
    step(1'b1, 1'b1);
    check("cs.credit0", credit_of(0), 0);
    check("cs.refund", refund_w[0], 1);
    step(1'b0, 1'b0);
    check("cs.refund_single", refund_w[0], 0);

    // Timeout with a coin on the expiry cycle
    repeat (3) step(1'b1, 1'b0);
    repeat (7) step(1'b0, 1'b0);
    check("to.no_early_refund", refund_w[0], 0);
    step(1'b1, 1'b0);
    check("to.refund", refund_w[0], 1);
    check("to.new_credit", credit_of(0), 1);
    check("to.lock", lock_w[0], 1);
    step(1'b0, 1'b0);
    check("to.refund_single", refund_w[0], 0);

    // Reset in the middle of a transaction
    do_reset();
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    check("mid.credit2", credit_of(0), 2);
    do_reset();
    step(1'b0, 1'b0);

    // PRICE 1 without timeout holds READY indefinitely
    step(1'b1, 1'b0);
    check("p1.ready", lock_w[2], 0);
    repeat (50) step(1'b0, 1'b0);
    check("p1.still_ready", lock_w[2], 0);
    check("p1.no_refund", refund_w[2], 0);
    step(1'b0, 1'b1);
    check("p1.relocked", lock_w[2], 1);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        do_reset();
      end else begin
        step(logic'($urandom_range(0, 9) < 4), logic'($urandom_range(0, 9) < 3));
      end
    end
    step(1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
